// File: rtl/hazard_fwd_unit_pkg.sv
// Shared widths, forwarding select encodings and the pipeline stage-entry record
// used by the hazard detection / forwarding unit.
package hazard_fwd_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [SEL_W-1:0] FWD_RF  = 2'd0;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'd1;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'd2;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
    logic     uses_rs;
    logic     uses_rt;
    logic     regwrite;
    logic     memread;
  } stage_t;

  // True when a stage will write a non-zero register that matches idx.
  function automatic logic writes_reg(logic wr, reg_idx_t rd, reg_idx_t idx);
    return wr & (rd != '0) & (rd == idx);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_match.sv
// Per-operand forwarding select: MEM result wins over WB data; $0 is never forwarded.
module fwd_match
  import hazard_fwd_unit_pkg::*;
(
  input  reg_idx_t         src,
  input  logic             uses,
  input  logic             mem_wr,
  input  reg_idx_t         mem_rd,
  input  logic             wb_wr,
  input  reg_idx_t         wb_rd,
  output logic [SEL_W-1:0] sel_c
);

  always_comb begin
    sel_c = FWD_RF;
    if (uses && writes_reg(mem_wr, mem_rd, src)) begin
      sel_c = FWD_MEM;
    end else if (uses && writes_reg(wb_wr, wb_rd, src)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Tracks EX/MEM/WB entries to drive EX operand forwarding selects and the
// one-cycle load-use stall, with a saturating stall-cycle counter.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_uses_rs_i,
  input  logic        id_uses_rt_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        flush_i,
  output logic [1:0]  fwd_a_sel_o,
  output logic [1:0]  fwd_b_sel_o,
  output logic        stall_o,
  output logic        bubble_o,
  output logic [15:0] stall_cnt_o
);

  stage_t             ex_q;
  stage_t             mem_q;
  stage_t             wb_q;
  stage_t             id_entry;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               load_use;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid_i;
    id_entry.rs       = id_rs_i;
    id_entry.rt       = id_rt_i;
    id_entry.rd       = id_rd_i;
    id_entry.uses_rs  = id_uses_rs_i;
    id_entry.uses_rt  = id_uses_rt_i;
    id_entry.regwrite = id_regwrite_i;
    id_entry.memread  = id_memread_i;
  end

  // A load in EX cannot feed the ID instruction in time; hold ID one cycle.
  always_comb begin
    load_use = id_valid_i & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
               ((id_uses_rs_i & (id_rs_i == ex_q.rd)) |
                (id_uses_rt_i & (id_rt_i == ex_q.rd)));
  end

  assign stall_o     = load_use & ~flush_i;
  assign bubble_o    = stall_o | flush_i | ~id_valid_i;
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble_o ? '0 : id_entry;
      if (stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  fwd_match u_fwd_a (
    .src    (ex_q.rs),
    .uses   (ex_q.uses_rs),
    .mem_wr (mem_q.valid & mem_q.regwrite),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid & wb_q.regwrite),
    .wb_rd  (wb_q.rd),
    .sel_c  (fwd_a_sel_o)
  );

  fwd_match u_fwd_b (
    .src    (ex_q.rt),
    .uses   (ex_q.uses_rt),
    .mem_wr (mem_q.valid & mem_q.regwrite),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid & wb_q.regwrite),
    .wb_rd  (wb_q.rd),
    .sel_c  (fwd_b_sel_o)
  );

  // WB only needs its destination fields; the rest ride along for completeness.
  logic unused_wb;
  assign unused_wb = ^{wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt, wb_q.memread};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scoreboard bench for hazard_fwd_unit: stimulus pushes expected
// outputs per cycle, an independent monitor pops and compares them.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic [4:0]  id_rd_i;
  logic        id_uses_rs_i;
  logic        id_uses_rt_i;
  logic        id_regwrite_i;
  logic        id_memread_i;
  logic        flush_i;
  logic [1:0]  fwd_a_sel_o;
  logic [1:0]  fwd_b_sel_o;
  logic        stall_o;
  logic        bubble_o;
  logic [15:0] stall_cnt_o;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_rd_i       (id_rd_i),
    .id_uses_rs_i  (id_uses_rs_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .fwd_a_sel_o   (fwd_a_sel_o),
    .fwd_b_sel_o   (fwd_b_sel_o),
    .stall_o       (stall_o),
    .bubble_o      (bubble_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct {
    string       nm;
    logic        chk;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        st;
    logic        bu;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, urs: 1'b0, urt: 1'b0, rw: 1'b0, mr: 1'b0};
    return i;
  endfunction

  function automatic ins_t r3(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    ins_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, rd: rd, urs: 1'b1, urt: 1'b1, rw: 1'b1, mr: 1'b0};
    return i;
  endfunction

  function automatic ins_t addi(logic [4:0] rt, logic [4:0] rs);
    ins_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, rd: rt, urs: 1'b1, urt: 1'b0, rw: 1'b1, mr: 1'b0};
    return i;
  endfunction

  function automatic ins_t lw(logic [4:0] rt, logic [4:0] rs);
    ins_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, rd: rt, urs: 1'b1, urt: 1'b0, rw: 1'b1, mr: 1'b1};
    return i;
  endfunction

  // Drive one ID-stage cycle and record the outputs expected during it.
  task automatic step(input string nm, input logic r, input logic fl, input ins_t i,
                      input logic [1:0] a, input logic [1:0] b, input logic st,
                      input logic bu, input logic [15:0] cnt, input logic chk = 1'b1);
    exp_t e;
    @(negedge clk);
    rst_i         = r;
    flush_i       = fl;
    id_valid_i    = i.v;
    id_rs_i       = i.rs;
    id_rt_i       = i.rt;
    id_rd_i       = i.rd;
    id_uses_rs_i  = i.urs;
    id_uses_rt_i  = i.urt;
    id_regwrite_i = i.rw;
    id_memread_i  = i.mr;
    e = '{nm: nm, chk: chk, a: a, b: b, st: st, bu: bu, cnt: cnt};
    sb.push_back(e);
  endtask

  task automatic nops(input int n, input logic [15:0] cnt);
    for (int k = 0; k < n; k++) step("nop", 1'b0, 1'b0, nop(), 2'd0, 2'd0, 1'b0, 1'b1, cnt);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp(e.nm, "fwd_a", 16'(fwd_a_sel_o), 16'(e.a));
          cmp(e.nm, "fwd_b", 16'(fwd_b_sel_o), 16'(e.b));
          cmp(e.nm, "stall", 16'(stall_o), 16'(e.st));
          cmp(e.nm, "bubble", 16'(bubble_o), 16'(e.bu));
          cmp(e.nm, "stall_cnt", stall_cnt_o, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    rst_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0;
    id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
    id_uses_rs_i = 1'b0; id_uses_rt_i = 1'b0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;

    step("rst0", 1'b1, 1'b0, nop(), 2'd0, 2'd0, 1'b0, 1'b1, 16'd0, 1'b0);
    step("rst1", 1'b1, 1'b0, nop(), 2'd0, 2'd0, 1'b0, 1'b1, 16'd0);

    // add $3,$1,$2 ; sub $4,$3,$5 -> MEM forward on A
    step("s1_add", 1'b0, 1'b0, r3(5'd3, 5'd1, 5'd2), 2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s1_sub", 1'b0, 1'b0, r3(5'd4, 5'd3, 5'd5), 2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s1_ex",  1'b0, 1'b0, nop(),                2'd1, 2'd0, 1'b0, 1'b1, 16'd0);
    nops(2, 16'd0);

    // add $3 ; independent ; or $6,$7,$3 -> WB forward on B
    step("s2_add", 1'b0, 1'b0, r3(5'd3, 5'd1, 5'd2),    2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s2_ind", 1'b0, 1'b0, r3(5'd11, 5'd12, 5'd13), 2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s2_or",  1'b0, 1'b0, r3(5'd6, 5'd7, 5'd3),    2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s2_ex",  1'b0, 1'b0, nop(),                   2'd0, 2'd2, 1'b0, 1'b1, 16'd0);
    nops(2, 16'd0);

    // add $3 ; addi $3,$3 ; and $8,$3,$3 -> MEM beats WB
    step("s3_add",  1'b0, 1'b0, r3(5'd3, 5'd1, 5'd2), 2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s3_addi", 1'b0, 1'b0, addi(5'd3, 5'd3),     2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s3_and",  1'b0, 1'b0, r3(5'd8, 5'd3, 5'd3), 2'd1, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s3_ex",   1'b0, 1'b0, nop(),                2'd1, 2'd1, 1'b0, 1'b1, 16'd0);
    nops(2, 16'd0);

    // lw $9 ; add $10,$9,$9 -> one stall, then WB forward on both
    step("s4_lw",    1'b0, 1'b0, lw(5'd9, 5'd1),         2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s4_stall", 1'b0, 1'b0, r3(5'd10, 5'd9, 5'd9),  2'd0, 2'd0, 1'b1, 1'b1, 16'd0);
    step("s4_hold",  1'b0, 1'b0, r3(5'd10, 5'd9, 5'd9),  2'd0, 2'd0, 1'b0, 1'b0, 16'd1);
    step("s4_ex",    1'b0, 1'b0, nop(),                  2'd2, 2'd2, 1'b0, 1'b1, 16'd1);
    nops(2, 16'd1);

    // flush coinciding with a load-use hazard
    step("s5_lw",    1'b0, 1'b0, lw(5'd9, 5'd1),        2'd0, 2'd0, 1'b0, 1'b0, 16'd1);
    step("s5_flush", 1'b0, 1'b1, r3(5'd10, 5'd9, 5'd9), 2'd0, 2'd0, 1'b0, 1'b1, 16'd1);
    step("s5_ex",    1'b0, 1'b0, nop(),                 2'd0, 2'd0, 1'b0, 1'b1, 16'd1);
    nops(2, 16'd1);

    // $0 is never a hazard or forwarding source
    step("s6_add0", 1'b0, 1'b0, r3(5'd0, 5'd1, 5'd2), 2'd0, 2'd0, 1'b0, 1'b0, 16'd1);
    step("s6_lw0",  1'b0, 1'b0, lw(5'd0, 5'd1),       2'd0, 2'd0, 1'b0, 1'b0, 16'd1);
    step("s6_rd0",  1'b0, 1'b0, r3(5'd5, 5'd0, 5'd0), 2'd0, 2'd0, 1'b0, 1'b0, 16'd1);
    step("s6_ex",   1'b0, 1'b0, nop(),                2'd0, 2'd0, 1'b0, 1'b1, 16'd1);
    nops(2, 16'd1);

    // preload counter near saturation
    @(posedge clk);
    #1;
    force dut.stall_cnt_q = 16'hFFFE;
    release dut.stall_cnt_q;

    step("s7_lw",    1'b0, 1'b0, lw(5'd9, 5'd1),        2'd0, 2'd0, 1'b0, 1'b0, 16'hFFFE);
    step("s7_st1",   1'b0, 1'b0, r3(5'd10, 5'd9, 5'd9), 2'd0, 2'd0, 1'b1, 1'b1, 16'hFFFE);
    step("s7_hold1", 1'b0, 1'b0, r3(5'd10, 5'd9, 5'd9), 2'd0, 2'd0, 1'b0, 1'b0, 16'hFFFF);
    step("s7_lw2",   1'b0, 1'b0, lw(5'd9, 5'd1),        2'd2, 2'd2, 1'b0, 1'b0, 16'hFFFF);
    step("s7_st2",   1'b0, 1'b0, r3(5'd10, 5'd9, 5'd9), 2'd0, 2'd0, 1'b1, 1'b1, 16'hFFFF);
    step("s7_sat",   1'b0, 1'b0, r3(5'd10, 5'd9, 5'd9), 2'd0, 2'd0, 1'b0, 1'b0, 16'hFFFF);
    step("s7_ex",    1'b0, 1'b0, nop(),                 2'd2, 2'd2, 1'b0, 1'b1, 16'hFFFF);
    nops(2, 16'hFFFF);

    // reset during a pending stall
    step("s8_lw",   1'b0, 1'b0, lw(5'd9, 5'd1),        2'd0, 2'd0, 1'b0, 1'b0, 16'hFFFF);
    step("s8_rst",  1'b1, 1'b0, r3(5'd10, 5'd9, 5'd9), 2'd0, 2'd0, 1'b1, 1'b1, 16'hFFFF);
    step("s8_post", 1'b0, 1'b0, r3(5'd10, 5'd9, 5'd9), 2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    step("s8_ex",   1'b0, 1'b0, nop(),                 2'd0, 2'd0, 1'b0, 1'b1, 16'd0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
